multicycle_ctrl: RTL
====================

# multicycle_ctrl

Multi-cycle control unit sequencing the processor datapath around the instruction field decoder. Steps each instruction through fetch, decode, execute, memory and write-back states, and drives the PC, instruction register, ALU, register-file and memory controls for the supported subset (R-type add/sub/and/or/slt/sll, ori, addi, lw, beq, j). Memory accesses use a req/ready handshake, so fetch and load latency may stretch.

## Interface
- no parameters
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- instr_op  in  6  instruction bits [31:26], valid from DECODE onward
- instr_funct  in  6  instruction bits [5:0]
- alu_zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes current request this cycle
- mem_req  out  1  memory request
- mem_sel  out  1  0 = instruction fetch, 1 = data load
- ir_write  out  1  load instruction register
- pc_write  out  1  load PC
- pc_src  out  2  0 = PC+4, 1 = branch target, 2 = jump target
- alu_op  out  3  0 ADD, 1 SUB, 2 OR, 3 AND, 4 SLT, 5 SLL
- alu_src_b  out  2  0 = rt reg, 2 = sign-ext imm, 3 = zero-ext imm
- reg_write  out  1  register-file write enable
- reg_dst  out  1  0 = rt, 1 = rd
- mem_to_reg  out  1  write-back from memory data
- trap  out  1  illegal instruction seen; sticky
- retired  out  32  retired-instruction count (see Configuration)

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP. Outputs combinational from state and latched instruction class; unlisted outputs 0.
- IDLE: all outputs 0; -> FETCH next cycle.
- FETCH: mem_req=1, mem_sel=0. mem_ready=1 -> ir_write=1, pc_write=1, pc_src=0, -> DECODE; else hold.
- DECODE: classify op/funct, register class. j: pc_write=1, pc_src=2, -> FETCH. Supported others -> EXEC. Unsupported op, or op 000000 with funct not in {100000,100010,100100,100101,101010,000000} -> TRAP.
- EXEC: R: alu_src_b=0, alu_op from funct (000000 -> SLL) -> WB. ori: OR, src 3 -> WB. addi: ADD, src 2 -> WB. lw: ADD, src 2 -> MEM. beq: SUB, src 0, pc_src=1, pc_write=alu_zero -> FETCH.
- MEM: mem_req=1, mem_sel=1; mem_ready=1 -> WB, else hold.
- WB: reg_write=1; reg_dst=1 for R-type only; mem_to_reg=1 for lw only -> FETCH.
- TRAP: all outputs 0 except trap=1; held until reset.

## Timing
- Reset: state IDLE, trap=0, retired=0, all controls 0.
- Handshake: mem_req held high until mem_ready sampled high at a rising edge; mem_ready while mem_req=0 is ignored. Exactly one request outstanding.
- Cycles per instruction with mem_ready tied 1 (FETCH to next FETCH): j 2, beq 3, R/ori/addi 4, lw 5. Each cycle mem_ready is low adds one.
- Retire point: DECODE for j, EXEC for beq, WB for others; first FETCH one cycle after IDLE.
- Reset asserted mid-instruction: immediate return to IDLE, pending request dropped, no register or PC write.

## Configuration
- CTRL_PERF_CNT_EN defined: retired increments by 1 on each retire-point cycle; wraps 0xFFFFFFFF -> 0; TRAP never retires.
- Undefined: retired tied to 0, no counter logic.

## Structure
- ctrl_pkg: state encoding, opcode/funct constants, alu_op, pc_src and alu_src_b codes, instruction-class enum.
- Sub-module ctrl_decode: combinational op/funct -> instruction class + legal flag; FSM instantiates it.

## Test plan
- Reset, mem_ready=1: IDLE 1 cycle, FETCH asserts mem_req=1, mem_sel=0; retired=0.
- addi (op 001000), mem_ready=1: 4-cycle sequence; EXEC alu_op=0, alu_src_b=2; WB reg_write=1, reg_dst=0; retired +1.
- lw (op 100011), mem_ready low 3 cycles in MEM: MEM held 4 cycles, mem_sel=1; WB mem_to_reg=1; total 8 cycles.
- beq with alu_zero=1 then alu_zero=0: pc_write=1 pc_src=1 in EXEC, then pc_write=0; both 3 cycles.
- j (op 000010): DECODE pc_write=1, pc_src=2, back to FETCH, 2 cycles; sll (funct 000000) gives alu_op=5, reg_dst=1.
- op 111111: TRAP, trap=1, mem_req stays 0 for 10 cycles; rst_n pulse low mid-MEM -> IDLE, trap=0, retired=0.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle control unit: FSM states, opcode/funct
// constants, datapath control codes and the instruction-class enum.
package ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_TRAP   = 3'd6
  } state_e;

  typedef enum logic [2:0] {
    CLS_R    = 3'd0,
    CLS_ORI  = 3'd1,
    CLS_ADDI = 3'd2,
    CLS_LW   = 3'd3,
    CLS_BEQ  = 3'd4,
    CLS_J    = 3'd5,
    CLS_ILL  = 3'd6
  } iclass_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;

  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_OR  = 3'd2;
  localparam logic [2:0] ALU_AND = 3'd3;
  localparam logic [2:0] ALU_SLT = 3'd4;
  localparam logic [2:0] ALU_SLL = 3'd5;

  localparam logic [1:0] PC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;

  localparam logic [1:0] SRCB_RT   = 2'd0;
  localparam logic [1:0] SRCB_SEXT = 2'd2;
  localparam logic [1:0] SRCB_ZEXT = 2'd3;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction classifier: op/funct -> class, legal flag and the
// ALU operation an R-type instruction will need in EXEC.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [5:0] op_i,
  input  logic [5:0] funct_i,
  output iclass_e    iclass_o,
  output logic       legal_o,
  output logic [2:0] r_alu_op_o
);

  // classify the opcode, and for R-type also validate the funct field
  always_comb begin
    iclass_o   = CLS_ILL;
    r_alu_op_o = ALU_ADD;
    case (op_i)
      OP_RTYPE: begin
        iclass_o = CLS_R;
        case (funct_i)
          FN_ADD:  r_alu_op_o = ALU_ADD;
          FN_SUB:  r_alu_op_o = ALU_SUB;
          FN_AND:  r_alu_op_o = ALU_AND;
          FN_OR:   r_alu_op_o = ALU_OR;
          FN_SLT:  r_alu_op_o = ALU_SLT;
          FN_SLL:  r_alu_op_o = ALU_SLL;
          default: iclass_o   = CLS_ILL;
        endcase
      end
      OP_ORI:  iclass_o = CLS_ORI;
      OP_ADDI: iclass_o = CLS_ADDI;
      OP_LW:   iclass_o = CLS_LW;
      OP_BEQ:  iclass_o = CLS_BEQ;
      OP_J:    iclass_o = CLS_J;
      default: iclass_o = CLS_ILL;
    endcase
  end

  assign legal_o = (iclass_o != CLS_ILL);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle FSM control unit (IDLE/FETCH/DECODE/EXEC/MEM/WB/TRAP).
// Define CTRL_PERF_CNT_EN to build the retired-instruction counter.
module multicycle_ctrl
  import ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  instr_op,
  input  logic [5:0]  instr_funct,
  input  logic        alu_zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_sel,
  output logic        ir_write,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic [2:0]  alu_op,
  output logic [1:0]  alu_src_b,
  output logic        reg_write,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        trap,
  output logic [31:0] retired
);

  state_e     state_q, state_d;
  iclass_e    cls_q, cls_d;
  logic [2:0] ralu_q, ralu_d;

  iclass_e    dec_cls_s;
  logic       dec_legal_s;
  logic [2:0] dec_ralu_s;

  ctrl_decode u_decode (
    .op_i       (instr_op),
    .funct_i    (instr_funct),
    .iclass_o   (dec_cls_s),
    .legal_o    (dec_legal_s),
    .r_alu_op_o (dec_ralu_s)
  );

  // state and latched instruction class
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cls_q   <= CLS_ILL;
      ralu_q  <= ALU_ADD;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      ralu_q  <= ralu_d;
    end
  end

  // next state and datapath controls
  always_comb begin
    state_d    = state_q;
    cls_d      = cls_q;
    ralu_d     = ralu_q;
    mem_req    = 1'b0;
    mem_sel    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = PC_PLUS4;
    alu_op     = ALU_ADD;
    alu_src_b  = SRCB_RT;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    trap       = 1'b0;
    case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = ST_DECODE;
        end else begin
          state_d  = ST_FETCH;
        end
      end
      ST_DECODE: begin
        cls_d  = dec_cls_s;
        ralu_d = dec_ralu_s;
        if (!dec_legal_s) begin
          state_d = ST_TRAP;
        end else if (dec_cls_s == CLS_J) begin
          pc_write = 1'b1;
          pc_src   = PC_JUMP;
          state_d  = ST_FETCH;
        end else begin
          state_d  = ST_EXEC;
        end
      end
      ST_EXEC: begin
        case (cls_q)
          CLS_R: begin
            alu_op  = ralu_q;
            state_d = ST_WB;
          end
          CLS_ORI: begin
            alu_op    = ALU_OR;
            alu_src_b = SRCB_ZEXT;
            state_d   = ST_WB;
          end
          CLS_ADDI: begin
            alu_src_b = SRCB_SEXT;
            state_d   = ST_WB;
          end
          CLS_LW: begin
            alu_src_b = SRCB_SEXT;
            state_d   = ST_MEM;
          end
          CLS_BEQ: begin
            alu_op   = ALU_SUB;
            pc_src   = PC_BRANCH;
            pc_write = alu_zero;
            state_d  = ST_FETCH;
          end
          default: state_d = ST_TRAP;
        endcase
      end
      ST_MEM: begin
        mem_req = 1'b1;
        mem_sel = 1'b1;
        if (mem_ready) begin
          state_d = ST_WB;
        end else begin
          state_d = ST_MEM;
        end
      end
      ST_WB: begin
        reg_write  = 1'b1;
        reg_dst    = (cls_q == CLS_R);
        mem_to_reg = (cls_q == CLS_LW);
        state_d    = ST_FETCH;
      end
      ST_TRAP: begin
        trap    = 1'b1;
        state_d = ST_TRAP;
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef CTRL_PERF_CNT_EN
  logic [31:0] retired_q, retired_d;
  logic        retire_s;

  // retire points: j in DECODE, beq in EXEC, everything else in WB
  always_comb begin
    retire_s  = ((state_q == ST_DECODE) && (dec_cls_s == CLS_J)) ||
                ((state_q == ST_EXEC) && (cls_q == CLS_BEQ)) ||
                (state_q == ST_WB);
    if (retire_s) begin
      retired_d = retired_q + 32'd1;
    end else begin
      retired_d = retired_q;
    end
  end

  // retired-instruction counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_q <= 32'd0;
    end else begin
      retired_q <= retired_d;
    end
  end

  assign retired = retired_q;
`else
  assign retired = 32'd0;
`endif

endmodule
